// File: rtl/square_iter.sv
// Iterative shift-add squarer: accepts x over valid/ready and returns min(x*x, 2^OUT_W-1)
// with an overflow flag. Latency is fixed and independent of the operand value.
module square_iter #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    localparam int PW = 2 * IN_W;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [IN_W-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [OUT_W-1:0] out_q,    out_d;
    logic             ovf_q,    ovf_d;

    // CALC runs IN_W shift-add iterations, then one more cycle that saturates the
    // finished product into the output registers before DONE.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{IN_W{1'b0}}, in};
                    mplier_d = in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q != LAST) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    ovf_d   = (acc_q >> OUT_W) != '0;
                    out_d   = ovf_d ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign ovf       = ovf_q;

endmodule
